fetch_unit: RTL



---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_queue.sv | 68 ++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline types and constants for the instruction-fetch front end.
package mips_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Parameterised synchronous circular FIFO of fetch entries with flush.
// Head reads as zero while empty so downstream sees clean data.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output fetch_entry_t             o_head,
    output logic                     o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;

    logic           w_full;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == (PW + 1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Callers must throttle pushes; an unpaired push into a full queue loses data.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_push && w_full && !i_pop && !i_flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, issues imem reads, queues results
// for decode, and handles redirects and fetch faults.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IQ_DEPTH   = 4,
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    output logic                          o_imem_req,
    output logic [31:0]                   o_imem_addr,
    input  logic [31:0]                   i_imem_rdata,
    input  logic                          i_redirect_valid,
    input  logic [31:0]                   i_redirect_pc,
    output logic                          o_dec_valid,
    output logic [31:0]                   o_dec_instr,
    output logic [31:0]                   o_dec_pc,
    input  logic                          i_dec_ready,
    output logic [$clog2(IQ_DEPTH):0]     o_iq_count,
    output logic                          o_fetch_fault
);

    localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

    fetch_state_e   r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_req_pc;
    logic           r_inflight;

    fetch_state_e   w_state_next;
    logic [31:0]    w_pc_next;
    logic           w_pop;
    logic           w_push;
    logic           w_issue;
    logic           w_pc_bad;
    logic [CW:0]    w_occupancy;
    logic [CW-1:0]  w_count;
    logic           w_empty;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_entry;

    assign w_pop       = o_dec_valid && i_dec_ready;
    // Entries the queue will hold once the in-flight response lands and this pop retires.
    assign w_occupancy = {1'b0, w_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
    assign w_pc_bad    = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= IMEM_WORDS);

    assign w_issue = !i_reset && (r_state != StHalt) && !i_redirect_valid && !w_pc_bad &&
                     (w_occupancy < (CW + 1)'(IQ_DEPTH));

    // A response landing in a redirect cycle belongs to the abandoned path.
    assign w_push       = r_inflight && !i_redirect_valid;
    assign w_push_entry = '{pc: r_req_pc, instr: i_imem_rdata};

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        unique case (r_state)
            StRun, StFlush: begin
                if (i_redirect_valid) begin
                    w_state_next = StFlush;
                end else if (w_pc_bad) begin
                    w_state_next = StHalt;
                end else begin
                    w_state_next = StRun;
                end
            end
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StRun;
        endcase
        if (i_redirect_valid) begin
            w_pc_next = i_redirect_pc;
        end else if (w_issue) begin
            w_pc_next = r_pc + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StRun;
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_fetch_queue (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (i_redirect_valid),
        .o_count      (w_count),
        .o_head       (w_head),
        .o_empty      (w_empty)
    );

    assign o_imem_req    = w_issue;
    assign o_imem_addr   = {r_pc[31:2], 2'b00};
    assign o_dec_valid   = !w_empty;
    assign o_dec_instr   = w_head.instr;
    assign o_dec_pc      = w_head.pc;
    assign o_iq_count    = w_count;
    assign o_fetch_fault = (r_state == StHalt);

endmodule
